// File: rtl/perf_snapshot_ctrl.sv
// Frame-synchronous snapshot of the cycle and seconds counters. The seconds value is
// converted to BCD by a one-step-per-cycle double-dabble engine before both values publish together.
module perf_snapshot_ctrl #(
  parameter int CYCLES_WIDTH  = 32,
  parameter int SECONDS_WIDTH = 14,
  parameter int BCD_DIGITS    = 5
) (
  input  logic                      CLK_50,
  input  logic                      resetN,
  input  logic                      frame_start,
  input  logic                      freeze,
  input  logic [CYCLES_WIDTH-1:0]   cycles_in,
  input  logic [SECONDS_WIDTH-1:0]  seconds_in,
  output logic [CYCLES_WIDTH-1:0]   snap_cycles,
  output logic [4*BCD_DIGITS-1:0]   seconds_bcd,
  output logic                      update_pulse,
  output logic                      busy,
  output logic [7:0]                drop_count
);

  localparam int BCD_W  = 4 * BCD_DIGITS;
  localparam int ITER_W = $clog2(SECONDS_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [CYCLES_WIDTH-1:0]    cyc_shadow_q, cyc_shadow_d;
  logic [SECONDS_WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [ITER_W-1:0]          iter_q, iter_d;
  logic [CYCLES_WIDTH-1:0]    snap_cycles_q, snap_cycles_d;
  logic [BCD_W-1:0]           seconds_bcd_q, seconds_bcd_d;
  logic                       update_pulse_q, update_pulse_d;
  logic [7:0]                 drop_count_q, drop_count_d;
  logic [BCD_W+SECONDS_WIDTH-1:0] dabble_s;

  // Double-dabble correction: every nibble of 5 or more gets 3 added, all in parallel.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Next-state, datapath and drop-counter logic.
  always_comb begin
    state_d        = state_q;
    cyc_shadow_d   = cyc_shadow_q;
    bin_d          = bin_q;
    bcd_d          = bcd_q;
    iter_d         = iter_q;
    snap_cycles_d  = snap_cycles_q;
    seconds_bcd_d  = seconds_bcd_q;
    update_pulse_d = 1'b0;
    drop_count_d   = drop_count_q;
    dabble_s       = {add3_nibbles(bcd_q), bin_q} << 1;

    case (state_q)
      IDLE: begin
        if (frame_start && !freeze) begin
          cyc_shadow_d = cycles_in;
          bin_d        = seconds_in;
          bcd_d        = '0;
          iter_d       = '0;
          state_d      = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = dabble_s;
        if (iter_q == ITER_W'(SECONDS_WIDTH - 1)) begin
          state_d = PUBLISH;
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      PUBLISH: begin
        snap_cycles_d  = cyc_shadow_q;
        seconds_bcd_d  = bcd_q;
        update_pulse_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Frames arriving mid-snapshot are counted regardless of freeze.
    if (frame_start && (state_q != IDLE) && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      cyc_shadow_q   <= '0;
      bin_q          <= '0;
      bcd_q          <= '0;
      iter_q         <= '0;
      snap_cycles_q  <= '0;
      seconds_bcd_q  <= '0;
      update_pulse_q <= 1'b0;
      drop_count_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      cyc_shadow_q   <= cyc_shadow_d;
      bin_q          <= bin_d;
      bcd_q          <= bcd_d;
      iter_q         <= iter_d;
      snap_cycles_q  <= snap_cycles_d;
      seconds_bcd_q  <= seconds_bcd_d;
      update_pulse_q <= update_pulse_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign snap_cycles  = snap_cycles_q;
  assign seconds_bcd  = seconds_bcd_q;
  assign update_pulse = update_pulse_q;
  assign busy         = (state_q != IDLE);
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_perf_snapshot_ctrl.sv
// Scoreboard bench for perf_snapshot_ctrl: a timing-level reference model queues expected
// publications, and a monitor checks every cycle's outputs against it.
module tb_perf_snapshot_ctrl;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        freeze;
  logic [31:0] cycles_in;
  logic [13:0] seconds_in;
  logic [31:0] snap_cycles;
  logic [19:0] seconds_bcd;
  logic        update_pulse;
  logic        busy;
  logic [7:0]  drop_count;

  perf_snapshot_ctrl dut (
    .CLK_50       (clk),
    .resetN       (rst_n),
    .frame_start  (frame_start),
    .freeze       (freeze),
    .cycles_in    (cycles_in),
    .seconds_in   (seconds_in),
    .snap_cycles  (snap_cycles),
    .seconds_bcd  (seconds_bcd),
    .update_pulse (update_pulse),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cyc;
    logic [19:0] bcd;
    int          due;
  } snap_t;

  snap_t       sb_q[$];
  int          checks = 0;
  int          passed = 0;

  // Reference model state: busy is a countdown of remaining snapshot cycles.
  int          edge_cnt = 0;
  int          busy_left = 0;
  int          m_drops = 0;
  logic        m_pulse = 1'b0;
  logic [31:0] m_pub_cyc = 32'd0;
  logic [19:0] m_pub_bcd = 20'd0;
  logic [31:0] m_pend_cyc = 32'd0;
  logic [19:0] m_pend_bcd = 20'd0;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    r = 20'd0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // Reference model: publish 15 edges after acceptance, drop frames while busy.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        busy_left  = 0;
        m_drops    = 0;
        m_pulse    = 1'b0;
        m_pub_cyc  = 32'd0;
        m_pub_bcd  = 20'd0;
        sb_q.delete();
      end else begin
        edge_cnt++;
        m_pulse = 1'b0;
        if (busy_left > 0) begin
          if (frame_start && m_drops < 255) m_drops++;
          busy_left--;
          if (busy_left == 0) begin
            m_pulse   = 1'b1;
            m_pub_cyc = m_pend_cyc;
            m_pub_bcd = m_pend_bcd;
          end
        end else if (frame_start && !freeze) begin
          busy_left  = 15;
          m_pend_cyc = cycles_in;
          m_pend_bcd = to_bcd(int'(seconds_in));
          sb_q.push_back('{cyc: m_pend_cyc, bcd: m_pend_bcd, due: edge_cnt + 15});
        end
      end
    end
  end

  // Monitor: compare every cycle, pop the scoreboard on each publication.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      chk("busy", busy, (busy_left != 0));
      chk("drop_count", drop_count, m_drops);
      chk("update_pulse", update_pulse, m_pulse);
      chk("snap_cycles", snap_cycles, m_pub_cyc);
      chk("seconds_bcd", seconds_bcd, m_pub_bcd);
      if (update_pulse === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_pulse", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_latency", edge_cnt, e.due);
          chk("sb_cycles", snap_cycles, e.cyc);
          chk("sb_bcd", seconds_bcd, e.bcd);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_and_wait(input logic [31:0] c, input logic [13:0] s, input int n);
    cycles_in   = c;
    seconds_in  = s;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (n) step();
  endtask

  int bvals[6] = '{0, 9, 10, 99, 100, 9999};

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; freeze = 1'b0;
    cycles_in = 32'd0; seconds_in = 14'd0;
    #2;
    // Reset held with random inputs.
    repeat (5) begin
      frame_start = 1'($urandom_range(0, 1));
      freeze      = 1'($urandom_range(0, 1));
      cycles_in   = $urandom;
      seconds_in  = 14'($urandom_range(0, 16383));
      step();
    end
    frame_start = 1'b0; freeze = 1'b0;
    rst_n = 1'b1;
    step();

    // Maximum value.
    pulse_and_wait(32'hDEADBEEF, 14'd16383, 18);

    // Digit boundaries.
    foreach (bvals[i]) pulse_and_wait($urandom, 14'(bvals[i]), 17);

    // Capture stability and drops at k+3 and k+15.
    cycles_in = 32'h12345678; seconds_in = 14'd4321;
    for (int i = 0; i <= 17; i++) begin
      frame_start = (i == 0 || i == 3 || i == 15);
      step();
      cycles_in  = $urandom;
      seconds_in = 14'($urandom_range(0, 16383));
    end
    frame_start = 1'b0;
    chk("drop_after_capture", drop_count, 2);
    repeat (3) step();

    // Freeze across three pulses, then release.
    freeze = 1'b1;
    repeat (3) pulse_and_wait($urandom, 14'($urandom_range(0, 16383)), 4);
    freeze = 1'b0;
    pulse_and_wait($urandom, 14'($urandom_range(0, 16383)), 17);

    // Freeze raised mid-conversion does not abort.
    pulse_and_wait(32'hCAFEF00D, 14'd777, 3);
    freeze = 1'b1;
    repeat (16) step();
    freeze = 1'b0;

    // Reset mid-conversion, then a clean snapshot.
    pulse_and_wait(32'hA5A5A5A5, 14'd1234, 4);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    pulse_and_wait(32'h0BADF00D, 14'd8191, 17);

    // Sparse random traffic.
    repeat (400) begin
      frame_start = ($urandom_range(0, 9) == 0);
      freeze      = ($urandom_range(0, 5) == 0);
      cycles_in   = $urandom;
      seconds_in  = 14'($urandom_range(0, 16383));
      step();
    end

    // Dense traffic to drive drop_count into saturation.
    repeat (1200) begin
      frame_start = 1'($urandom_range(0, 1));
      freeze      = ($urandom_range(0, 7) == 0);
      cycles_in   = $urandom;
      seconds_in  = 14'($urandom_range(0, 16383));
      step();
    end
    frame_start = 1'b0; freeze = 1'b0;
    repeat (20) step();
    chk("drop_saturated", drop_count, 8'd255);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
